// File: rtl/double_shift_left_seq_pkg.sv
// Shared definitions for the double shift left unit: default word length,
// controller state encoding and a state decode helper.
package double_shift_left_seq_pkg;

   localparam int WORD_LENGTH = 32;

   typedef enum logic [1:0] {
      DSL_IDLE  = 2'b00,
      DSL_SHIFT = 2'b01,
      DSL_DONE  = 2'b10
   } dsl_state_e;

   // The unused encoding 2'b11 behaves exactly like IDLE.
   function automatic logic dsl_is_idle(input dsl_state_e s);
      return (s != DSL_SHIFT) && (s != DSL_DONE);
   endfunction

endpackage

// File: rtl/double_shift_left_seq_if.sv
// Operand/result handshake bundle for the double shift left unit.
// Vectors are descending; the MSB-first bit 0 of a/b/sa/y is the top bit here.
interface double_shift_left_seq_if
   import double_shift_left_seq_pkg::*;
#(
   parameter int WIDTH = WORD_LENGTH
);
   localparam int SA_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SA_W-1:0]  sa;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;

   modport master (
      output in_valid, a, b, sa, out_ready,
      input  in_ready, out_valid, y
   );

   modport slave (
      input  in_valid, a, b, sa, out_ready,
      output in_ready, out_valid, y
   );

endinterface

// File: rtl/double_shift_left_seq_dsl_step.sv
// One resolution step: conditionally shifts the 2*WIDTH register left by
// WIDTH >> (step+1), zero-filling from the right.
module dsl_step
   import double_shift_left_seq_pkg::*;
#(
   parameter int WIDTH = WORD_LENGTH,
   localparam int SA_W = $clog2(WIDTH)
) (
   input  logic [2*WIDTH-1:0] data_i,
   input  logic               en_i,
   input  logic [SA_W-1:0]    step_i,
   output logic [2*WIDTH-1:0] data_o
);

   int shamt_s;

   always_comb begin
      shamt_s = WIDTH >> (int'(step_i) + 1);
      if (en_i) begin
         data_o = data_i << shamt_s;
      end else begin
         data_o = data_i;
      end
   end

endmodule

// File: rtl/double_shift_left_seq.sv
// Multi-cycle double shift left: y = upper WIDTH bits of ({a,b} << sa),
// resolving one shift-amount bit (MSB first) per clock.
module double_shift_left_seq
   import double_shift_left_seq_pkg::*;
#(
   parameter int WIDTH = WORD_LENGTH
) (
   input logic                    clk,
   input logic                    rst,
   double_shift_left_seq_if.slave bus
);

   localparam int SA_W = $clog2(WIDTH);
   localparam logic [SA_W-1:0] LAST_STEP = SA_W'(SA_W - 1);

   dsl_state_e           state_q, state_d;
   logic [2*WIDTH-1:0]   sr_q, sr_d;
   logic [SA_W-1:0]      sa_q, sa_d;
   logic [SA_W-1:0]      step_q, step_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic                 out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0]   step_res_s;
   logic                 in_ready_s;

   assign in_ready_s    = dsl_is_idle(state_q) & ~rst;
   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;

   // sa_q is shifted left each step so its top bit is always the current step's enable.
   dsl_step #(.WIDTH(WIDTH)) u_step (
      .data_i (sr_q),
      .en_i   (sa_q[SA_W-1]),
      .step_i (step_q),
      .data_o (step_res_s)
   );

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      sa_d        = sa_q;
      step_d      = step_q;
      y_d         = y_q;
      out_valid_d = out_valid_q;
      case (state_q)
         DSL_SHIFT: begin
            sr_d   = step_res_s;
            sa_d   = sa_q << 1;
            step_d = step_q + SA_W'(1);
            if (step_q == LAST_STEP) begin
               state_d     = DSL_DONE;
               step_d      = '0;
               y_d         = step_res_s[2*WIDTH-1 -: WIDTH];
               out_valid_d = 1'b1;
            end else begin
               state_d = DSL_SHIFT;
            end
         end
         DSL_DONE: begin
            if (bus.out_ready) begin
               state_d     = DSL_IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = DSL_DONE;
            end
         end
         default: begin
            if (bus.in_valid && in_ready_s) begin
               state_d = DSL_SHIFT;
               sr_d    = {bus.a, bus.b};
               sa_d    = bus.sa;
               step_d  = '0;
            end else begin
               state_d = state_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= DSL_IDLE;
         sr_q        <= '0;
         sa_q        <= '0;
         step_q      <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         sa_q        <= sa_d;
         step_q      <= step_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_double_shift_left_seq.sv
// Self-checking bench for double_shift_left_seq: directed vectors, back-pressure,
// mid-operation reset and randomized operations against an arithmetic reference.
module tb_double_shift_left_seq;

   localparam int W    = 32;
   localparam int SA_W = 5;
   localparam int LAT  = SA_W;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   double_shift_left_seq_if #(.WIDTH(W)) bus_if ();

   double_shift_left_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_dsl(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [SA_W-1:0] sa);
      logic [2*W-1:0] cat;
      cat = {a, b};
      cat = cat << sa;
      return cat[2*W-1:W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one op, run to DONE (optionally poking ignored in_valid), hold, release.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SA_W-1:0] sa, input int hold, input logic [W-1:0] exp_y);
      int k;
      logic [W-1:0] y0;
      check_eq({tag, "_in_ready"}, {63'd0, bus_if.in_ready}, 64'd1);
      bus_if.in_valid = 1'b1;
      bus_if.a  = a;
      bus_if.b  = b;
      bus_if.sa = sa;
      tick();
      k = 0;
      while (k < 20) begin
         bus_if.in_valid = 1'($urandom_range(0, 1));
         bus_if.a  = $urandom;
         bus_if.b  = $urandom;
         bus_if.sa = 5'($urandom);
         tick();
         k++;
         if (bus_if.out_valid) break;
      end
      bus_if.in_valid = 1'b0;
      check_eq({tag, "_latency"}, 64'(k), 64'(LAT));
      check_eq({tag, "_y"}, {32'd0, bus_if.y}, {32'd0, exp_y});
      y0 = bus_if.y;
      for (int i = 0; i < hold; i++) begin
         tick();
         check_eq({tag, "_hold_y"}, {32'd0, bus_if.y}, {32'd0, y0});
         check_eq({tag, "_hold_valid"}, {63'd0, bus_if.out_valid}, 64'd1);
      end
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      check_eq({tag, "_released"}, {63'd0, bus_if.out_valid}, 64'd0);
      check_eq({tag, "_y_kept"}, {32'd0, bus_if.y}, {32'd0, y0});
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [SA_W-1:0] rs;
      int k;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.sa        = '0;
      bus_if.out_ready = 1'b0;
      tick();
      check_eq("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
      check_eq("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
      check_eq("rst_y", {32'd0, bus_if.y}, 64'd0);
      rst = 1'b0;
      #1;

      run_op("v1", 32'h0000FF0F, 32'h00000FFF, 5'd5, 0, 32'h001FE1E0);
      run_op("v2", 32'h12345678, 32'h9ABCDEF0, 5'd8, 1, 32'h3456789A);
      run_op("v3", 32'h12345678, 32'h9ABCDEF0, 5'd0, 0, 32'h12345678);
      run_op("v4", 32'hAAAA5555, 32'h1234FFFF, 5'd16, 2, 32'h55551234);
      run_op("v5", 32'h00000001, 32'h80000000, 5'd31, 0, 32'hC0000000);

      // Back-pressure with competing operands presented in DONE.
      bus_if.in_valid = 1'b1;
      bus_if.a = 32'h0000FF0F; bus_if.b = 32'h00000FFF; bus_if.sa = 5'd5;
      tick();
      bus_if.in_valid = 1'b0;
      repeat (LAT) tick();
      check_eq("bp_valid", {63'd0, bus_if.out_valid}, 64'd1);
      bus_if.in_valid = 1'b1;
      bus_if.a = 32'h12345678; bus_if.b = 32'h9ABCDEF0; bus_if.sa = 5'd8;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("bp_y", {32'd0, bus_if.y}, 64'h001FE1E0);
         check_eq("bp_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
         check_eq("bp_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
      end
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      check_eq("bp_idle_ready", {63'd0, bus_if.in_ready}, 64'd1);
      check_eq("bp_idle_valid", {63'd0, bus_if.out_valid}, 64'd0);
      tick();
      bus_if.in_valid = 1'b0;
      check_eq("bp_accepted", {63'd0, bus_if.in_ready}, 64'd0);
      k = 0;
      while (k < 20 && !bus_if.out_valid) begin
         tick();
         k++;
      end
      check_eq("bp_new_latency", 64'(k), 64'(LAT));
      check_eq("bp_new_y", {32'd0, bus_if.y}, 64'h3456789A);
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;

      // Reset in the middle of the shift sequence.
      bus_if.in_valid = 1'b1;
      bus_if.a = 32'hFFFFFFFF; bus_if.b = 32'h0; bus_if.sa = 5'd4;
      tick();
      bus_if.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", {63'd0, bus_if.out_valid}, 64'd0);
      check_eq("mid_rst_y", {32'd0, bus_if.y}, 64'd0);
      check_eq("mid_rst_ready", {63'd0, bus_if.in_ready}, 64'd0);
      tick();
      check_eq("mid_rst_hold_valid", {63'd0, bus_if.out_valid}, 64'd0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_ready", {63'd0, bus_if.in_ready}, 64'd1);
      run_op("post_rst", 32'h0F0F0F0F, 32'hF0000000, 5'd4, 0, 32'hF0F0F0FF);

      // Randomized operations with random back-pressure.
      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 5'($urandom);
         if (n == 0) rs = 5'd31;
         if (n == 1) rs = 5'd0;
         run_op("rnd", ra, rb, rs, $urandom_range(0, 3), ref_dsl(ra, rb, rs));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/double_shift_left_seq.md
Name: double_shift_left_seq

Overview:
- Multi-cycle double shift left unit, the left-direction counterpart of the shift/merge datapath's double shift right.
- Concatenates operands A:B, shifts the 2*WIDTH-bit value left by SA, and returns the upper WIDTH bits.
- Resolves one shift-amount bit per clock, giving a fixed latency, behind valid/ready handshakes on both input and output.
- Used by the execute stage for shift-left/deposit sequences where a full barrel shifter is not affordable.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two.
- SA_W, $clog2(WIDTH) (5 for the default), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands presented.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  high word, bit 0 is the MSB (bit numbering [0:WIDTH-1]).
- b  in  WIDTH  low word, bit 0 is the MSB.
- sa  in  SA_W  shift amount 0..WIDTH-1; sa[0] is the MSB (weight WIDTH/2).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- y  out  WIDTH  result: bits [0:WIDTH-1] of ((a:b) << sa).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, y=0, internal 2*WIDTH-bit shift register=0, step counter=0.
- in_ready is combinational: (state==IDLE) & ~rst. It is 0 while rst is high.
- States: IDLE, SHIFT, DONE.
- IDLE: an edge with in_valid & in_ready captures a:b into the shift register and sa into an sa register, sets step=0, and moves to SHIFT.
- IDLE: input values when in_valid=0 are ignored.
- SHIFT: at each edge, if sa_reg[step] is 1, the register shifts left by WIDTH >> (step+1), zero-filled from the right; otherwise it holds.
- SHIFT: step increments each edge.
- SHIFT: at the edge where step==SA_W-1, the final step is applied and the state moves to DONE.
- SHIFT to DONE edge: y is loaded with the upper WIDTH bits of the post-step value and out_valid is set to 1.
- Latency: out_valid rises exactly SA_W edges after the accept edge (5 for the default). There is no early exit for sa=0.
- DONE: y and out_valid hold stable while out_ready=0 (unbounded back-pressure).
- DONE: an edge with out_ready=1 clears out_valid and moves to IDLE.
- y is not cleared on leaving DONE; it keeps the last value until the next DONE load.
- Throughput: one operation per SA_W+2 cycles. in_valid asserted in SHIFT or DONE is ignored, not queued.
- Arithmetic: bits shifted out on the left are discarded. The register is wide enough that no low bits are lost for sa <= WIDTH-1.
- sa=0 gives y=a.
- Reset mid-operation (SHIFT or DONE): outputs return to reset values immediately, the pending operation is lost, and no partial result is ever presented.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Shared package / VCPU32 include file holds:
  - WORD_LENGTH (32), the default for WIDTH.
  - DSL state encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Unused encoding 2'b11 decodes to IDLE.
- One sub-module, dsl_step: combinational, takes the 2*WIDTH register, the enable bit, and a step index, and returns the conditionally shifted value. It is instantiated once and muxed by step.

Test Plan:
- a=0x0000FF0F, b=0x00000FFF, sa=5 -> out_valid 5 cycles after accept, y=0x001FE1E0.
- a=0x12345678, b=0x9ABCDEF0, sa=8 -> y=0x3456789A.
- a=0x12345678, b=0x9ABCDEF0, sa=0 -> y=0x12345678.
- a=0xAAAA5555, b=0x1234FFFF, sa=16 -> y=0x55551234.
- a=0x00000001, b=0x80000000, sa=31 -> y=0xC0000000.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE and drive in_valid=1 with new operands -> y stays stable, in_ready=0, new operands are not captured.
- Back-pressure, continued: release out_ready -> IDLE next cycle, new operands accepted the following edge.
- Reset mid-op: accept a=0xFFFFFFFF, b=0, sa=4, then assert rst during step 2 -> out_valid=0 and y=0 immediately, in_ready=0 while rst is high.
- Reset mid-op, continued: after rst deasserts, in_ready=1 and the next op (a=0x0F0F0F0F, b=0xF0000000, sa=4) returns y=0xF0F0F0FF.
